// File: rtl/fan_pwm_driver.sv
// rtl/fan_pwm_driver.sv - fan mode filter, duty ramp, PWM generator and tach stall monitor
module fan_pwm_driver #(
    parameter int PWM_PERIOD    = 16,
    parameter int MODE_HOLD     = 3,
    parameter int RAMP_DIV      = 4,
    parameter int STALL_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] fan_mode,
    input  logic       tach,
    output logic       pwm_out,
    output logic [4:0] duty,
    output logic [2:0] mode_ack,
    output logic       busy,
    output logic       stall
);
    localparam int PW = $clog2(PWM_PERIOD);
    localparam int HW = $clog2(MODE_HOLD);
    localparam int DW = $clog2(RAMP_DIV);
    localparam int SW = $clog2(STALL_TIMEOUT);

    typedef enum logic [2:0] {IDLE, RAMP_UP, RAMP_DOWN, RUN, STALL} state_t;

    state_t        state_q, state_d;
    logic [2:0]    cand_q, cand_d, mode_ack_q, mode_ack_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [DW-1:0] div_q, div_d;
    logic [SW-1:0] stall_cnt_q, stall_cnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [4:0]    cmp_q, cmp_d, duty_q, duty_d;
    logic          pwm_q, pwm_d, busy_q, busy_d, stall_q, stall_d;
    logic          tach_s1_q, tach_s1_d, tach_s2_q, tach_s2_d, tach_prev_q, tach_prev_d;
    logic          tach_rise;
    logic [4:0]    target;
    logic [4:0]    next_duty;
    logic          go_up;

    always_comb begin
        case (mode_ack_q)
            3'd0:    target = 5'd0;
            3'd1:    target = 5'd4;
            3'd2:    target = 5'd8;
            3'd3:    target = 5'd12;
            default: target = 5'd16;
        endcase
    end

    assign tach_rise = tach_s2_q & ~tach_prev_q;

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        hold_d      = hold_q;
        mode_ack_d  = mode_ack_q;
        div_d       = div_q;
        stall_cnt_d = '0;
        duty_d      = duty_q;
        stall_d     = stall_q;
        next_duty   = duty_q;
        go_up       = target > duty_q;
        tach_s1_d   = tach;
        tach_s2_d   = tach_s1_q;
        tach_prev_d = tach_s2_q;

        // Candidate must be seen MODE_HOLD times in a row, counting the loading sample.
        if (fan_mode != cand_q) begin
            cand_d = fan_mode;
            hold_d = '0;
        end else begin
            if (hold_q != HW'(MODE_HOLD - 1)) hold_d = hold_q + 1'b1;
            if (hold_q == HW'(MODE_HOLD - 2) && cand_q != mode_ack_q) mode_ack_d = cand_q;
        end

        case (state_q)
            IDLE: begin
                duty_d = '0;
                if (target != 5'd0) begin
                    state_d = RAMP_UP;
                    div_d   = '0;
                end
            end
            RAMP_UP, RAMP_DOWN: begin
                if (target == duty_q) begin
                    state_d = (target == 5'd0) ? IDLE : RUN;
                end else if ((state_q == RAMP_UP) != go_up) begin
                    state_d = go_up ? RAMP_UP : RAMP_DOWN;
                    div_d   = '0;
                end else if (div_q == DW'(RAMP_DIV - 1)) begin
                    div_d     = '0;
                    next_duty = go_up ? duty_q + 1'b1 : duty_q - 1'b1;
                    duty_d    = next_duty;
                    if (next_duty == target) state_d = (target == 5'd0) ? IDLE : RUN;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            RUN: begin
                if (target > duty_q) begin
                    state_d = RAMP_UP;
                    div_d   = '0;
                end else if (target < duty_q) begin
                    state_d = RAMP_DOWN;
                    div_d   = '0;
                end else if (!tach_rise && stall_cnt_q == SW'(STALL_TIMEOUT - 1)) begin
                    state_d = STALL;
                    duty_d  = '0;
                    stall_d = 1'b1;
                end else begin
                    stall_cnt_d = tach_rise ? '0 : stall_cnt_q + 1'b1;
                end
            end
            STALL: begin
                duty_d = '0;
                if (mode_ack_q == 3'd0) begin
                    state_d = IDLE;
                    stall_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RAMP_UP) || (state_d == RAMP_DOWN);

        // Compare value only follows duty at the period boundary.
        pcnt_d = (pcnt_q == PW'(PWM_PERIOD - 1)) ? '0 : pcnt_q + 1'b1;
        cmp_d  = (pcnt_q == PW'(PWM_PERIOD - 1)) ? duty_q : cmp_q;
        pwm_d  = !stall_q && (5'(pcnt_d) < cmp_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            hold_q      <= '0;
            mode_ack_q  <= '0;
            div_q       <= '0;
            stall_cnt_q <= '0;
            pcnt_q      <= '0;
            cmp_q       <= '0;
            duty_q      <= '0;
            pwm_q       <= 1'b0;
            busy_q      <= 1'b0;
            stall_q     <= 1'b0;
            tach_s1_q   <= 1'b0;
            tach_s2_q   <= 1'b0;
            tach_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            hold_q      <= hold_d;
            mode_ack_q  <= mode_ack_d;
            div_q       <= div_d;
            stall_cnt_q <= stall_cnt_d;
            pcnt_q      <= pcnt_d;
            cmp_q       <= cmp_d;
            duty_q      <= duty_d;
            pwm_q       <= pwm_d;
            busy_q      <= busy_d;
            stall_q     <= stall_d;
            tach_s1_q   <= tach_s1_d;
            tach_s2_q   <= tach_s2_d;
            tach_prev_q <= tach_prev_d;
        end
    end

    assign pwm_out  = pwm_q;
    assign duty     = duty_q;
    assign mode_ack = mode_ack_q;
    assign busy     = busy_q;
    assign stall    = stall_q;
endmodule

// File: tb/tb_fan_pwm_driver.sv
// tb/tb_fan_pwm_driver.sv - directed self-checking bench for fan_pwm_driver
module tb_fan_pwm_driver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] fan_mode = 3'd0;
    logic       tach_man = 1'b0;
    logic       tach_gen = 1'b0;
    logic       tach_auto = 1'b0;
    logic       tach;
    logic       pwm_out;
    logic [4:0] duty;
    logic [2:0] mode_ack;
    logic       busy;
    logic       stall;
    int         checks = 0;
    int         failures = 0;
    int         gen_cnt = 0;

    assign tach = tach_auto ? tach_gen : tach_man;

    fan_pwm_driver dut (
        .clk(clk), .rst_n(rst_n), .fan_mode(fan_mode), .tach(tach),
        .pwm_out(pwm_out), .duty(duty), .mode_ack(mode_ack), .busy(busy), .stall(stall)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (gen_cnt == 9) begin
            gen_cnt  <= 0;
            tach_gen <= ~tach_gen;
        end else begin
            gen_cnt <= gen_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({pwm_out, duty, mode_ack, busy, stall} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {pwm_out, duty, mode_ack, busy, stall});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_glitch();
        int highs = 0;
        @(negedge clk);
        fan_mode = 3'b010;
        @(negedge clk);
        @(negedge clk);
        fan_mode = 3'b000;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (pwm_out) highs++;
        end
        checks++;
        if (mode_ack !== 3'd0) begin failures++; $display("FAIL glitch_ack got=%0d exp=0", mode_ack); end
        checks++;
        if (duty !== 5'd0) begin failures++; $display("FAIL glitch_duty got=%0d exp=0", duty); end
        checks++;
        if (highs !== 0) begin failures++; $display("FAIL glitch_pwm highs=%0d exp=0", highs); end
    endtask

    task automatic test_ramp_up();
        int highs = 0;
        tach_auto = 1'b1;
        @(negedge clk);
        fan_mode = 3'b001;
        tick(); tick();
        checks++;
        if (mode_ack !== 3'd0) begin failures++; $display("FAIL ack_early got=%0d exp=0", mode_ack); end
        tick();
        checks++;
        if (mode_ack !== 3'd1) begin failures++; $display("FAIL ack_third got=%0d exp=1", mode_ack); end
        tick();
        checks++;
        if (busy !== 1'b1 || duty !== 5'd0) begin
            failures++; $display("FAIL ramp_start busy=%0b duty=%0d exp busy=1 duty=0", busy, duty);
        end
        repeat (4) tick();
        checks++;
        if (duty !== 5'd1) begin failures++; $display("FAIL first_step got=%0d exp=1", duty); end
        repeat (11) tick();
        checks++;
        if (duty !== 5'd3 || busy !== 1'b1) begin
            failures++; $display("FAIL pre_run duty=%0d busy=%0b exp 3/1", duty, busy);
        end
        tick();
        checks++;
        if (duty !== 5'd4 || busy !== 1'b0) begin
            failures++; $display("FAIL run_reached duty=%0d busy=%0b exp 4/0", duty, busy);
        end
        repeat (20) tick();
        for (int i = 0; i < 32; i++) begin
            tick();
            if (pwm_out) highs++;
        end
        checks++;
        if (highs !== 8) begin failures++; $display("FAIL pwm_duty4 highs=%0d exp=8", highs); end
    endtask

    task automatic test_ramp_down();
        @(negedge clk);
        fan_mode = 3'b011;
        repeat (50) tick();
        checks++;
        if (duty !== 5'd12 || busy !== 1'b0) begin
            failures++; $display("FAIL up_to_12 duty=%0d busy=%0b exp 12/0", duty, busy);
        end
        @(negedge clk);
        fan_mode = 3'b001;
        repeat (4) tick();
        checks++;
        if (busy !== 1'b1 || duty !== 5'd12) begin
            failures++; $display("FAIL down_start busy=%0b duty=%0d exp 1/12", busy, duty);
        end
        repeat (31) tick();
        checks++;
        if (duty !== 5'd5 || busy !== 1'b1) begin
            failures++; $display("FAIL down_pre duty=%0d busy=%0b exp 5/1", duty, busy);
        end
        tick();
        checks++;
        if (duty !== 5'd4 || busy !== 1'b0) begin
            failures++; $display("FAIL down_done duty=%0d busy=%0b exp 4/0", duty, busy);
        end
    endtask

    task automatic test_stall();
        int highs = 0;
        @(negedge clk);
        fan_mode = 3'b010;
        repeat (30) tick();
        @(negedge clk);
        tach_auto = 1'b0;
        tach_man  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i % 10 == 0) tach_man = ~tach_man;
        end
        checks++;
        if (stall !== 1'b0 || duty !== 5'd8) begin
            failures++; $display("FAIL tach_running stall=%0b duty=%0d exp 0/8", stall, duty);
        end
        @(negedge clk);
        tach_man = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            tick();
            if (k == 5) tach_man = 1'b0;
            if (k == 34) begin
                checks++;
                if (stall !== 1'b0 || duty !== 5'd8) begin
                    failures++; $display("FAIL stall_early stall=%0b duty=%0d exp 0/8", stall, duty);
                end
            end
            if (k == 35) begin
                checks++;
                if (stall !== 1'b1 || duty !== 5'd0) begin
                    failures++; $display("FAIL stall_set stall=%0b duty=%0d exp 1/0", stall, duty);
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (pwm_out) highs++;
            tick();
        end
        checks++;
        if (highs !== 0) begin failures++; $display("FAIL stall_pwm highs=%0d exp=0", highs); end
    endtask

    task automatic test_stall_exit();
        @(negedge clk);
        fan_mode = 3'b010;
        repeat (10) tick();
        checks++;
        if (stall !== 1'b1 || duty !== 5'd0) begin
            failures++; $display("FAIL stall_sticky stall=%0b duty=%0d exp 1/0", stall, duty);
        end
        @(negedge clk);
        fan_mode = 3'b000;
        repeat (3) tick();
        checks++;
        if (stall !== 1'b1 || mode_ack !== 3'd0) begin
            failures++; $display("FAIL exit_pre stall=%0b ack=%0d exp 1/0", stall, mode_ack);
        end
        tick();
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL exit_idle stall=%0b busy=%0b exp 0/0", stall, busy);
        end
        tach_auto = 1'b1;
        @(negedge clk);
        fan_mode = 3'b010;
        repeat (35) tick();
        checks++;
        if (duty !== 5'd7 || busy !== 1'b1) begin
            failures++; $display("FAIL reramp_pre duty=%0d busy=%0b exp 7/1", duty, busy);
        end
        tick();
        checks++;
        if (duty !== 5'd8 || busy !== 1'b0 || stall !== 1'b0) begin
            failures++; $display("FAIL reramp_done duty=%0d busy=%0b stall=%0b exp 8/0/0", duty, busy, stall);
        end
    endtask

    task automatic test_full_and_reset();
        int highs = 0;
        @(negedge clk);
        fan_mode = 3'b111;
        repeat (50) tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            if (pwm_out) highs++;
        end
        checks++;
        if (duty !== 5'd16 || highs !== 16) begin
            failures++; $display("FAIL full_on duty=%0d highs=%0d exp 16/16", duty, highs);
        end
        @(negedge clk);
        fan_mode = 3'b000;
        repeat (80) tick();
        checks++;
        if (duty !== 5'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL down_to_idle duty=%0d busy=%0b exp 0/0", duty, busy);
        end
        @(negedge clk);
        fan_mode = 3'b111;
        repeat (32) tick();
        checks++;
        if (duty !== 5'd7 || busy !== 1'b1 || mode_ack !== 3'd7) begin
            failures++; $display("FAIL mid_ramp duty=%0d busy=%0b ack=%0d exp 7/1/7", duty, busy, mode_ack);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pwm_out, duty, mode_ack, busy, stall} !== 11'd0) begin
            failures++; $display("FAIL async_reset got=%b exp=0", {pwm_out, duty, mode_ack, busy, stall});
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_ramp_up();
        test_ramp_down();
        test_stall();
        test_stall_exit();
        test_full_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fan_pwm_driver.md
Name: fan_pwm_driver

Overview:
- Consumes the 3-bit fan_mode command from the cooling-system controller and drives the physical fan.
- Filters mode glitches, ramps PWM duty toward the commanded level and generates the PWM waveform.
- Watches the fan tachometer and flags a stalled rotor.
- Sits between the cooling FSM and the fan power stage.

Parameters:
- PWM_PERIOD, 16: PWM period in clk cycles; duty range 0..PWM_PERIOD.
- MODE_HOLD, 3: consecutive identical fan_mode samples required before a new mode is accepted.
- RAMP_DIV, 4: clk cycles per single duty step while ramping.
- STALL_TIMEOUT, 32: clk cycles in RUN with no tach rising edge before stall is declared.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fan_mode  in  3  commanded mode from cooling controller.
- tach  in  1  fan tachometer pulse, asynchronous to clk.
- pwm_out  out  1  PWM drive to fan power stage.
- duty  out  5  current applied duty (0..16).
- mode_ack  out  3  last accepted (filtered) mode.
- busy  out  1  high while ramping.
- stall  out  1  sticky stall flag.

Behaviour:
- Reset (rst_n low, async): pwm_out=0, duty=0, mode_ack=000, busy=0, stall=0, state=IDLE, all counters 0, tach synchronizer cleared.
- Mode filter:
  - Samples fan_mode every cycle into a candidate register plus hold counter.
  - Any sample differing from the candidate reloads the candidate and clears the counter.
  - On the MODE_HOLD-th consecutive equal sample that differs from mode_ack, mode_ack takes the candidate on that edge.
  - A stable value equal to mode_ack is a no-op.
- Target duty from mode_ack: 000→0, 001→4, 010→8, 011→12, 100..111→16 (saturate).
- Ramp:
  - A RAMP_DIV divider runs only in RAMP_UP and RAMP_DOWN.
  - On each divider expiry, duty moves exactly 1 toward target.
  - The divider restarts on entry to either ramp state.
- PWM:
  - Free-running period counter 0..PWM_PERIOD-1.
  - Compare value loads from duty only when the counter wraps to 0, so there are no mid-period glitches.
  - pwm_out is registered: high when counter < compare value. Compare 0 means constantly low; 16 means constantly high.
- Tach: 2-flop synchronizer, then a rising-edge detect (1-cycle pulse).
- FSM states:
  - IDLE: duty=0. If target>0 → RAMP_UP.
  - RAMP_UP: busy=1. When duty==target → RUN. If target drops below duty → RAMP_DOWN.
  - RAMP_DOWN: busy=1. When duty==target → RUN, or IDLE if target==0. If target rises above duty → RAMP_UP.
  - RUN:
    - The stall counter increments each cycle and clears on a tach edge.
    - Reaching STALL_TIMEOUT → STALL.
    - target>duty → RAMP_UP; target<duty → RAMP_DOWN; target==0 → RAMP_DOWN.
  - STALL: duty forced to 0 on entry (immediate, no ramp), stall=1, pwm_out low from the next cycle. Exit only when mode_ack becomes 000 → IDLE, with stall cleared on that same edge.
- Stall counter is cleared in every state other than RUN, so spin-up time is not counted.
- Mode changes while ramping retarget the ramp without returning to IDLE.
- A mode change in the same cycle as a tach edge: both take effect.
- rst_n assertion mid-ramp or mid-stall returns everything to reset values immediately.

Test Plan:
- Reset then fan_mode=001 held → mode_ack=001 on 3rd sampling edge; busy=1; duty steps 0→4 in 16 cycles (one step every 4); RUN; pwm_out high 4 of every 16 cycles.
- fan_mode pulses 010 for 2 cycles then back to 000 → mode_ack stays 000, duty stays 0, pwm_out never high.
- In RUN at duty 12 (mode 011), change to 001 → RAMP_DOWN, duty 12→4 over 32 cycles, busy drops on reaching 4; pwm_out compare changes only at period wrap.
- RUN at duty 8 with tach toggling every 10 cycles for 200 cycles → stall stays 0. Then hold tach low → stall=1 exactly 32 cycles after entering the no-edge window, duty=0, pwm_out low.
- While stalled, fan_mode=010 → stall stays 1. Then fan_mode=000 held 3 cycles → stall=0, state IDLE. Then 010 → normal ramp to 8.
- Mode 111 → target 16, pwm_out constantly high after ramp. Assert rst_n low mid-ramp (duty=7) → all outputs 0 asynchronously, before the next clk edge.
